// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard FSM, pipeline-register enables/flushes and EX/WB forwarding for a 3-stage pipeline
// Ports:
//   clk            falling edge updates the FSM, on the same edge as the pipeline registers
//   reset          asynchronous, active-high; returns the FSM to RUN with cnt=0
//   freeze         global hold: every write enable drops and the FSM holds
//   idRs/idRt/idUsesRs/idUsesRt                   source fields of the ID instruction
//   exRs/exRt/exRd/exRegWrite/exLoad/exBranchTaken fields held in ID/EX
//   wbRd/wbRegWrite                               destination held in EX/WB
//   pcWrite, ifidWrite/ifidFlush, idexWrite/idexFlush, exwbWrite  pipeline control
//   fwdA/fwdB      EX operand taken from the EX/WB result
//   hazState       00 RUN, 01 STALL, 10 FLUSH
// Optional HAZARD_PERF_CNT_EN: adds saturating stallCount/flushCount outputs.
module pipeline_hazard_ctrl #(
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic [2:0] idRs,
  input  logic [2:0] idRt,
  input  logic       idUsesRs,
  input  logic       idUsesRt,
  input  logic [2:0] exRs,
  input  logic [2:0] exRt,
  input  logic [2:0] exRd,
  input  logic       exRegWrite,
  input  logic       exLoad,
  input  logic       exBranchTaken,
  input  logic [2:0] wbRd,
  input  logic       wbRegWrite,
  output logic       pcWrite,
  output logic       ifidWrite,
  output logic       ifidFlush,
  output logic       idexWrite,
  output logic       idexFlush,
  output logic       exwbWrite,
  output logic       fwdA,
  output logic       fwdB,
  output logic [1:0] hazState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
`endif
);
  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] STALL = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;
  localparam logic [2:0] LL_CNT = 3'(LOAD_LATENCY - 1);
  localparam logic [2:0] FC_CNT = 3'(FLUSH_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic load_use, in_run, stall, flush;
  assign load_use = exLoad & exRegWrite &
                    ((idUsesRs & (idRs == exRd)) | (idUsesRt & (idRt == exRd)));
  // the unused encoding 11 behaves as RUN
  assign in_run = (state_q == RUN) || (state_q == 2'b11);
  // a taken branch outranks a load-use hazard; in STALL the EX bubble makes the branch irrelevant
  assign flush = (state_q == FLUSH) || (in_run && exBranchTaken);
  assign stall = (state_q == STALL) || (in_run && !exBranchTaken && load_use);
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (!freeze)
      case (state_q)
        RUN:
          if (exBranchTaken) begin
            state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            cnt_d = FC_CNT;
          end else if (load_use) begin
            state_d = LOAD_LATENCY > 1 ? STALL : RUN;
            cnt_d = LL_CNT;
          end
        STALL, FLUSH: begin
          cnt_d = cnt_q - 3'd1;
          state_d = cnt_q <= 3'd1 ? RUN : state_q;
        end
        default: begin
          state_d = RUN;
          cnt_d = '0;
        end
      endcase
  end
  always_comb begin
    pcWrite = !freeze && !stall;
    ifidWrite = !freeze && !stall;
    ifidFlush = !freeze && flush;
    idexWrite = !freeze;
    idexFlush = !freeze && (stall || flush);
    exwbWrite = !freeze;
    fwdA = wbRegWrite && (wbRd == exRs);
    fwdB = wbRegWrite && (wbRd == exRt);
    hazState = state_q;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = (!freeze && !pcWrite && !(&stall_cnt_q)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (ifidFlush && !(&flush_cnt_q)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif
endmodule
